// File: rtl/camera_bayer_demosaic.sv
// Bayer-to-RGB demosaic using a 2x2 window (one buffered previous line).
// Emits one RGB pixel with coordinates two clocks after each qualifying sensor sample.
module camera_bayer_demosaic #(
  parameter int         VIDEO_W       = 1920,
  parameter int         VIDEO_H       = 1080,
  parameter int         LINE_MAX      = 2048,
  parameter logic [1:0] BAYER_PATTERN = 2'd0
) (
  input  logic        CAMERA_PIXCLK,
  input  logic        reset_n,
  input  logic [11:0] CAMERA_D,
  input  logic        CAMERA_FVAL,
  input  logic        CAMERA_LVAL,
  output logic [11:0] RGB_R,
  output logic [11:0] RGB_G,
  output logic [11:0] RGB_B,
  output logic [11:0] RGB_X,
  output logic [11:0] RGB_Y,
  output logic        RGB_VALID
);

  localparam int          AW = $clog2(LINE_MAX);
  localparam logic [12:0] LM = 13'(LINE_MAX);

  if (VIDEO_W >= LINE_MAX || VIDEO_H >= 4095 || LINE_MAX > 4096 ||
      (LINE_MAX & (LINE_MAX - 1)) != 0) begin : g_bad_geometry
    $error("camera_bayer_demosaic: unsupported LINE_MAX / VIDEO_W / VIDEO_H");
  end

  logic [11:0] r_d;
  logic        r_fval, r_fval_q, r_lval, r_lval_q;
  logic        r_armed;
  logic [12:0] r_x;
  logic [11:0] r_y;
  logic [11:0] r_mem [LINE_MAX];
  logic [11:0] r_top, r_top_q, r_cur, r_cur_q;
  logic        r_wvld, r_wpx, r_wpy;
  logic [11:0] r_wx, r_wy;

  logic          w_fval_rise, w_fval_fall, w_lval_rise, w_lval_fall;
  logic [12:0]   w_x_eff;
  logic [11:0]   w_y_eff;
  logic          w_pix, w_wr, w_out;
  logic [AW-1:0] w_addr;
  logic [12:0]   w_gsum;
  logic [11:0]   w_r, w_b;

  assign w_fval_rise = r_fval & ~r_fval_q;
  assign w_fval_fall = ~r_fval & r_fval_q;
  assign w_lval_rise = r_lval & ~r_lval_q;
  assign w_lval_fall = ~r_lval & r_lval_q;
  assign w_x_eff     = w_lval_rise ? 13'd0 : r_x;
  assign w_y_eff     = w_fval_rise ? 12'd0 : r_y;
  assign w_pix       = r_fval & r_lval & (r_armed | w_fval_rise);
  assign w_wr        = w_pix & (w_x_eff < LM);
  assign w_out       = w_wr & (w_x_eff != 13'd0) & (w_y_eff != 12'd0);
  assign w_addr      = w_x_eff[AW-1:0];

  // FVAL history resets high so a frame already running at reset release shows no rising edge.
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_d      <= 12'd0;
      r_fval   <= 1'b1;
      r_fval_q <= 1'b1;
      r_lval   <= 1'b0;
      r_lval_q <= 1'b0;
    end else begin
      r_d      <= CAMERA_D;
      r_fval   <= CAMERA_FVAL;
      r_fval_q <= r_fval;
      r_lval   <= CAMERA_LVAL;
      r_lval_q <= r_lval;
    end
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
      r_x     <= 13'd0;
      r_y     <= 12'd0;
    end else begin
      if (w_fval_rise) begin
        r_armed <= 1'b1;
      end else if (w_fval_fall) begin
        r_armed <= 1'b0;
      end
      if (w_pix) begin
        r_x <= (w_x_eff >= LM) ? LM : w_x_eff + 13'd1;
      end else if (w_lval_rise) begin
        r_x <= 13'd0;
      end
      // A line ending on the same edge as the frame still counts (FVAL history is used).
      if (w_fval_rise) begin
        r_y <= 12'd0;
      end else if (w_lval_fall && r_fval_q && r_armed && r_y != 12'hFFF) begin
        r_y <= r_y + 12'd1;
      end
    end
  end

  // Read-before-write line buffer: r_top receives the pixel one row above.
  always_ff @(posedge CAMERA_PIXCLK) begin
    if (w_wr) begin
      r_top          <= r_mem[w_addr];
      r_mem[w_addr]  <= r_d;
    end
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_cur   <= 12'd0;
      r_cur_q <= 12'd0;
      r_top_q <= 12'd0;
      r_wvld  <= 1'b0;
      r_wpx   <= 1'b0;
      r_wpy   <= 1'b0;
      r_wx    <= 12'd0;
      r_wy    <= 12'd0;
    end else begin
      r_wvld <= w_out;
      if (w_wr) begin
        r_cur   <= r_d;
        r_cur_q <= r_cur;
        r_top_q <= r_top;
      end
      if (w_out) begin
        r_wx  <= w_x_eff[11:0] - 12'd1;
        r_wy  <= w_y_eff - 12'd1;
        r_wpx <= w_x_eff[0] ^ BAYER_PATTERN[0];
        r_wpy <= w_y_eff[0] ^ BAYER_PATTERN[1];
      end
    end
  end

  // Bottom-right site parity decides where R, B and the two G samples sit in the window.
  always_comb begin
    w_gsum = 13'd0;
    w_r    = 12'd0;
    w_b    = 12'd0;
    case ({r_wpx == r_wpy, r_wpx})
      2'b11: begin
        w_gsum = {1'b0, r_cur} + {1'b0, r_top_q};
        w_r    = r_top;
        w_b    = r_cur_q;
      end
      2'b10: begin
        w_gsum = {1'b0, r_cur} + {1'b0, r_top_q};
        w_r    = r_cur_q;
        w_b    = r_top;
      end
      2'b01: begin
        w_gsum = {1'b0, r_top} + {1'b0, r_cur_q};
        w_r    = r_cur;
        w_b    = r_top_q;
      end
      2'b00: begin
        w_gsum = {1'b0, r_top} + {1'b0, r_cur_q};
        w_r    = r_top_q;
        w_b    = r_cur;
      end
      default: begin
        w_gsum = 13'd0;
        w_r    = 12'd0;
        w_b    = 12'd0;
      end
    endcase
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      RGB_R     <= 12'd0;
      RGB_G     <= 12'd0;
      RGB_B     <= 12'd0;
      RGB_X     <= 12'd0;
      RGB_Y     <= 12'd0;
      RGB_VALID <= 1'b0;
    end else begin
      RGB_VALID <= r_wvld;
      if (r_wvld) begin
        RGB_R <= w_r;
        RGB_G <= w_gsum[12:1];
        RGB_B <= w_b;
        RGB_X <= r_wx;
        RGB_Y <= r_wy;
      end
    end
  end

endmodule

// File: tb/tb_camera_bayer_demosaic.sv
// Scoreboard bench: three demosaic instances (GRBG, RGGB, BGGR with a 16-deep line)
// share one sensor stream; a frame-level model predicts every output pixel and its cycle.
module tb_camera_bayer_demosaic;

  typedef struct {
    int x, y, r, g, b, due;
  } exp_t;

  localparam int PATS [3] = '{0, 1, 2};
  localparam int LMS  [3] = '{2048, 2048, 16};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] dat;
  logic        fval, lval;
  logic [11:0] o_r [3];
  logic [11:0] o_g [3];
  logic [11:0] o_b [3];
  logic [11:0] o_x [3];
  logic [11:0] o_y [3];
  logic        o_vld [3];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   vcnt [3];
  exp_t q [3][$];
  exp_t got;
  int   pix [0:7][0:31];
  bit   ign;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  camera_bayer_demosaic #(.LINE_MAX(2048), .BAYER_PATTERN(2'd0)) u_grbg (
    .CAMERA_PIXCLK(clk), .reset_n(reset_n), .CAMERA_D(dat), .CAMERA_FVAL(fval),
    .CAMERA_LVAL(lval), .RGB_R(o_r[0]), .RGB_G(o_g[0]), .RGB_B(o_b[0]),
    .RGB_X(o_x[0]), .RGB_Y(o_y[0]), .RGB_VALID(o_vld[0]));

  camera_bayer_demosaic #(.LINE_MAX(2048), .BAYER_PATTERN(2'd1)) u_rggb (
    .CAMERA_PIXCLK(clk), .reset_n(reset_n), .CAMERA_D(dat), .CAMERA_FVAL(fval),
    .CAMERA_LVAL(lval), .RGB_R(o_r[1]), .RGB_G(o_g[1]), .RGB_B(o_b[1]),
    .RGB_X(o_x[1]), .RGB_Y(o_y[1]), .RGB_VALID(o_vld[1]));

  camera_bayer_demosaic #(.VIDEO_W(15), .VIDEO_H(3), .LINE_MAX(16), .BAYER_PATTERN(2'd2)) u_small (
    .CAMERA_PIXCLK(clk), .reset_n(reset_n), .CAMERA_D(dat), .CAMERA_FVAL(fval),
    .CAMERA_LVAL(lval), .RGB_R(o_r[2]), .RGB_G(o_g[2]), .RGB_B(o_b[2]),
    .RGB_X(o_x[2]), .RGB_Y(o_y[2]), .RGB_VALID(o_vld[2]));

  // 0 = G, 1 = R, 2 = B for the sensor site at column c, row r.
  function automatic int site_col(input int c, input int r, input int pat);
    int cp = c ^ (pat & 1);
    int rp = r ^ ((pat >> 1) & 1);
    if ((cp & 1) == (rp & 1)) return 0;
    if ((cp & 1) == 1) return 1;
    return 2;
  endfunction

  function automatic int px_val(input int kind, input int c, input int r);
    int col = site_col(c, r, 0);
    int rnd = int'($urandom & 32'hFFF);
    case (kind)
      0: return (col == 0) ? 32'h100 : (col == 1) ? 32'h200 : 32'h300;
      2: return (col != 0) ? rnd : ((c % 2 == 0) ? 32'hFFF : 32'hFFE);
      3: return (col != 0) ? rnd : ((c % 2 == 0) ? 32'h001 : 32'h000);
      default: return rnd;
    endcase
  endfunction

  task automatic push_px(input int c, input int r, input int stamp);
    for (int i = 0; i < 3; i++) begin
      if (c >= 1 && r >= 1 && c < LMS[i]) begin
        exp_t e;
        int gs = 0;
        e.r = 0; e.b = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int v = pix[r - 1 + dy][c - 1 + dx];
            case (site_col(c - 1 + dx, r - 1 + dy, PATS[i]))
              0: gs += v;
              1: e.r = v;
              default: e.b = v;
            endcase
          end
        end
        e.g = gs / 2;
        e.x = c - 1;
        e.y = r - 1;
        e.due = stamp + 2;
        q[i].push_back(e);
      end
    end
  endtask

  task automatic tick(input logic f, input logic l, input int d);
    @(posedge clk);
    #1;
    fval = f;
    lval = l;
    dat  = 12'(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) q[i].delete();
    ign = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drive_frame(input int w, input int h, input int kind, input int gap, input int rst_row);
    ign = 1'b0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == rst_row && c == 3) do_reset();
        pix[r][c] = px_val(kind, c, r);
        tick(1'b1, 1'b1, pix[r][c]);
        if (!ign) push_px(c, r, cyc + 1);
      end
      if (r < h - 1) begin
        for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, int'($urandom & 32'hFFF));
      end
    end
    repeat (3) tick(1'b0, 1'b0, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest prediction, including its cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_vld[i] === 1'b1) begin
        vcnt[i]++;
        tests++;
        if (q[i].size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid dut%0d cyc=%0d got X=%0d Y=%0d required no output",
                   i, cyc, o_x[i], o_y[i]);
        end else begin
          got = q[i].pop_front();
          if (int'(o_x[i]) != got.x || int'(o_y[i]) != got.y || int'(o_r[i]) != got.r ||
              int'(o_g[i]) != got.g || int'(o_b[i]) != got.b || cyc != got.due) begin
            fails++;
            $display("FAIL pixel dut%0d got X=%0d Y=%0d R=%h G=%h B=%h cyc=%0d required X=%0d Y=%0d R=%h G=%h B=%h cyc=%0d",
                     i, o_x[i], o_y[i], o_r[i], o_g[i], o_b[i], cyc,
                     got.x, got.y, got.r, got.g, got.b, got.due);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) vcnt[i] = 0;
    reset_n = 1'b0;
    fval = 1'b1;
    lval = 1'b1;
    dat  = 12'hA5A;
    repeat (4) begin
      @(posedge clk);
      #1 dat = ~dat;
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({o_r[i], o_g[i], o_b[i], o_x[i], o_y[i], o_vld[i]} != 61'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d got R=%h G=%h B=%h X=%h Y=%h V=%b required all 0",
                 i, o_r[i], o_g[i], o_b[i], o_x[i], o_y[i], o_vld[i]);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) tick(1'b1, 1'b1, (k % 2 == 0) ? 32'hFFF : 32'h000);
    repeat (3) tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (vcnt[i] != 0) begin
        fails++;
        $display("FAIL no_output_after_reset dut%0d got %0d strobes required 0", i, vcnt[i]);
      end
    end

    drive_frame(8, 4, 0, 2, -1);
    drive_frame(8, 4, 2, 2, -1);
    drive_frame(8, 4, 3, 1, -1);
    drive_frame(20, 4, 1, 2, -1);
    drive_frame(8, 4, 0, 2, 2);
    drive_frame(8, 4, 0, 2, -1);
    for (int f = 0; f < 4; f++) begin
      drive_frame(int'($urandom_range(4, 20)), int'($urandom_range(2, 6)), 1,
                  int'($urandom_range(1, 4)), -1);
    end

    repeat (10) tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (q[i].size() != 0) begin
        fails++;
        $display("FAIL missing_outputs dut%0d got %0d outstanding required 0", i, q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
